// File: rtl/paramshadow.sv
// Multi-word parameter shadow bank: bus-written staging words are committed as a set
// and handed to the consumer atomically on its sync strobe (or at once in immediate mode).
module paramshadow #(
    parameter int                PW            = 32,
    parameter int                NCH           = 4,
    parameter int                LGNCH         = 2,
    parameter logic [NCH*PW-1:0] RESET_VALUE   = {NCH*PW{1'b0}},
    parameter logic              OPT_IMMEDIATE = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_wr,
    input  logic [LGNCH-1:0]  i_addr,
    input  logic [PW-1:0]     i_data,
    input  logic              i_commit,
    input  logic              i_sync,
    output logic [NCH*PW-1:0] o_params,
    output logic              o_pending,
    output logic              o_update,
    output logic [7:0]        o_overruns,
    output logic [PW-1:0]     o_rdata
);

    logic [NCH*PW-1:0] staging_r, pending_r, active_r;
    logic [NCH*PW-1:0] staging_s, pending_s, active_s;
    logic              pending_flag_r, pending_flag_s;
    logic              update_r, update_s;
    logic [7:0]        overruns_r, overruns_s;
    logic [PW-1:0]     rdata_r, rdata_s;
    logic              apply_s;

    // Staging write (seen by a same-cycle commit) and pre-write readback mux.
    always_comb begin
        staging_s = staging_r;
        rdata_s   = {PW{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            staging_s[k*PW +: PW] = (i_wr && (i_addr == LGNCH'(k))) ? i_data
                                                                    : staging_r[k*PW +: PW];
            rdata_s = rdata_s | ({PW{i_addr == LGNCH'(k)}} & staging_r[k*PW +: PW]);
        end
    end

    // Commit/sync sequencing: old pending set is applied before a same-cycle commit replaces it.
    always_comb begin
        active_s       = active_r;
        pending_s      = pending_r;
        pending_flag_s = pending_flag_r;
        update_s       = 1'b0;
        overruns_s     = overruns_r;
        apply_s        = 1'b0;
        if (OPT_IMMEDIATE) begin
            if (i_commit) begin
                active_s = staging_s;
                update_s = 1'b1;
            end else begin
                active_s = active_r;
            end
        end else begin
            apply_s = i_sync & pending_flag_r;
            if (apply_s) begin
                active_s       = pending_r;
                update_s       = 1'b1;
                pending_flag_s = 1'b0;
            end else begin
                active_s = active_r;
            end
            if (i_commit) begin
                pending_s      = staging_s;
                pending_flag_s = 1'b1;
                if (pending_flag_r && !apply_s && (overruns_r != 8'hFF)) begin
                    overruns_s = overruns_r + 8'd1;
                end else begin
                    overruns_s = overruns_r;
                end
            end else begin
                pending_s = pending_r;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            staging_r      <= RESET_VALUE;
            pending_r      <= RESET_VALUE;
            active_r       <= RESET_VALUE;
            pending_flag_r <= 1'b0;
            update_r       <= 1'b0;
            overruns_r     <= 8'd0;
            rdata_r        <= {PW{1'b0}};
        end else begin
            staging_r      <= staging_s;
            pending_r      <= pending_s;
            active_r       <= active_s;
            pending_flag_r <= pending_flag_s;
            update_r       <= update_s;
            overruns_r     <= overruns_s;
            rdata_r        <= rdata_s;
        end
    end

    assign o_params   = active_r;
    assign o_pending  = pending_flag_r;
    assign o_update   = update_r;
    assign o_overruns = overruns_r;
    assign o_rdata    = rdata_r;

endmodule

// File: tb/tb_paramshadow.sv
// Bench for paramshadow: a deferred 4-word instance and an immediate 3-word instance
// share one stimulus stream and are checked every cycle against a word-array model.
module tb_paramshadow;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr, commit, sync;
    logic [1:0]  addr;
    logic [31:0] data;

    logic [127:0] p0;
    logic [95:0]  p1;
    logic         pend0, pend1, upd0, upd1;
    logic [7:0]   ovr0, ovr1;
    logic [31:0]  rd0, rd1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    paramshadow #(.PW(32), .NCH(4), .LGNCH(2), .OPT_IMMEDIATE(1'b0)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_wr(wr), .i_addr(addr), .i_data(data),
        .i_commit(commit), .i_sync(sync), .o_params(p0), .o_pending(pend0),
        .o_update(upd0), .o_overruns(ovr0), .o_rdata(rd0));

    paramshadow #(.PW(32), .NCH(3), .LGNCH(2), .OPT_IMMEDIATE(1'b1)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_wr(wr), .i_addr(addr), .i_data(data),
        .i_commit(commit), .i_sync(sync), .o_params(p1), .o_pending(pend1),
        .o_update(upd1), .o_overruns(ovr1), .o_rdata(rd1));

    // Model: index 0 = deferred NCH=4, index 1 = immediate NCH=3.
    logic [31:0] m_stg [2][4];
    logic [31:0] m_pend[2][4];
    logic [31:0] m_act [2][4];
    bit          m_pf  [2];
    bit          m_upd [2];
    int          m_ovr [2];
    logic [31:0] m_rd  [2];

    function automatic int nch(int m);
        return (m == 0) ? 4 : 3;
    endfunction

    function automatic logic [127:0] packed_act(int m);
        logic [127:0] r = '0;
        for (int k = 0; k < nch(m); k++) r[k*32 +: 32] = m_act[m][k];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model advanced on every rising edge.
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            bit hit;
            if (!rst_n) begin
                for (int k = 0; k < 4; k++) begin
                    m_stg[m][k] = '0; m_pend[m][k] = '0; m_act[m][k] = '0;
                end
                m_pf[m] = 0; m_upd[m] = 0; m_ovr[m] = 0; m_rd[m] = '0;
            end else begin
                m_rd[m] = (int'(addr) < nch(m)) ? m_stg[m][addr] : 32'd0;
                if (wr && int'(addr) < nch(m)) m_stg[m][addr] = data;
                m_upd[m] = 0;
                if (m == 1) begin
                    if (commit) begin
                        for (int k = 0; k < 4; k++) m_act[1][k] = m_stg[1][k];
                        m_upd[1] = 1;
                    end
                end else begin
                    hit = sync && m_pf[0];
                    if (commit && m_pf[0] && !hit) m_ovr[0] = (m_ovr[0] >= 255) ? 255 : m_ovr[0] + 1;
                    if (hit) begin
                        for (int k = 0; k < 4; k++) m_act[0][k] = m_pend[0][k];
                        m_upd[0] = 1;
                        m_pf[0]  = 0;
                    end
                    if (commit) begin
                        for (int k = 0; k < 4; k++) m_pend[0][k] = m_stg[0][k];
                        m_pf[0] = 1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("params0",   {{0{1'b0}}, p0},  packed_act(0));
            chk("pending0",  128'(pend0),      128'(m_pf[0]));
            chk("update0",   128'(upd0),       128'(m_upd[0]));
            chk("overruns0", 128'(ovr0),       128'(m_ovr[0]));
            chk("rdata0",    128'(rd0),        128'(m_rd[0]));
            chk("params1",   128'(p1),         packed_act(1));
            chk("pending1",  128'(pend1),      128'(m_pf[1]));
            chk("update1",   128'(upd1),       128'(m_upd[1]));
            chk("overruns1", 128'(ovr1),       128'(m_ovr[1]));
            chk("rdata1",    128'(rd1),        128'(m_rd[1]));
        end
    end

    task automatic drive(input logic w, input logic [1:0] a, input logic [31:0] d,
                         input logic c, input logic s);
        wr = w; addr = a; data = d; commit = c; sync = s;
        @(negedge clk);
        wr = 1'b0; commit = 1'b0; sync = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr = 1'b0; addr = 2'd0; data = 32'd0; commit = 1'b0; sync = 1'b0;
        drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("rst_params", p0, 128'd0);
        chk("rst_pending", 128'(pend0), 128'd0);
        chk("rst_overruns", 128'(ovr0), 128'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b1);
            chk("idle_sync_update", 128'(upd0), 128'd0);
            chk("idle_sync_params", p0, 128'd0);
        end

        // Basic set, deferred until sync.
        for (int k = 0; k < 4; k++) drive(1'b1, 2'(k), 32'((k + 1) * 17), 1'b0, 1'b0);
        drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
        chk("commit_pending", 128'(pend0), 128'd1);
        for (int i = 0; i < 5; i++) drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
        chk("held_params", p0, 128'd0);
        drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b1);
        chk("sync_params", p0, 128'h00000044_00000033_00000022_00000011);
        chk("sync_update", 128'(upd0), 128'd1);
        drive(1'b0, 2'd2, 32'd0, 1'b0, 1'b0);
        chk("update_pulse_end", 128'(upd0), 128'd0);
        chk("pending_clear", 128'(pend0), 128'd0);
        chk("readback_w2", 128'(rd0), 128'h33);

        // Write-through commit.
        drive(1'b1, 2'd0, 32'hAA, 1'b1, 1'b0);
        drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b1);
        chk("writethrough", p0, 128'h00000044_00000033_00000022_000000AA);

        // Single overrun.
        drive(1'b1, 2'd0, 32'd1, 1'b1, 1'b0);
        drive(1'b1, 2'd0, 32'd2, 1'b1, 1'b0);
        drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b1);
        chk("overrun_word0", 128'(p0[31:0]), 128'd2);
        chk("overrun_count", 128'(ovr0), 128'd1);

        // Commit with sync while a set is pending.
        drive(1'b1, 2'd0, 32'hA, 1'b1, 1'b0);
        drive(1'b1, 2'd0, 32'hB, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b1);
        chk("cs_applied_A", 128'(p0[31:0]), 128'hA);
        chk("cs_still_pending", 128'(pend0), 128'd1);
        chk("cs_no_overrun", 128'(ovr0), 128'd1);
        drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b1);
        chk("cs_applied_B", 128'(p0[31:0]), 128'hB);
        chk("cs_pending_clear", 128'(pend0), 128'd0);

        // Commit with sync while nothing pending: applied only by a later sync.
        drive(1'b1, 2'd0, 32'hC, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b1);
        chk("cs0_no_update", 128'(upd0), 128'd0);
        chk("cs0_pending", 128'(pend0), 128'd1);
        drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b1);
        chk("cs0_applied", 128'(p0[31:0]), 128'hC);

        // Saturation of the overrun counter.
        drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
            drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
        end
        chk("overrun_saturate", 128'(ovr0), 128'd255);

        // Reset while a set is pending.
        drive(1'b1, 2'd0, 32'hD, 1'b1, 1'b0);
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b1);
        rst_n = 1'b1;
        chk("reset_params", p0, 128'd0);
        chk("reset_pending", 128'(pend0), 128'd0);
        chk("reset_overruns", 128'(ovr0), 128'd0);
        drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b1);
        chk("reset_sync_no_update", 128'(upd0), 128'd0);

        // Immediate instance.
        drive(1'b1, 2'd1, 32'h5, 1'b0, 1'b0);
        drive(1'b0, 2'd1, 32'd0, 1'b1, 1'b0);
        chk("imm_word1", 128'(p1), 128'h00000000_00000005_00000000);
        chk("imm_update", 128'(upd1), 128'd1);
        chk("imm_pending", 128'(pend1), 128'd0);
        drive(1'b0, 2'd1, 32'd0, 1'b0, 1'b1);
        chk("imm_sync_ignored", 128'(upd1), 128'd0);
        drive(1'b1, 2'd3, 32'h99, 1'b0, 1'b0);
        drive(1'b0, 2'd3, 32'd0, 1'b1, 1'b0);
        chk("imm_oob_ignored", 128'(p1), 128'h00000000_00000005_00000000);
        chk("imm_oob_readback", 128'(rd1), 128'd0);
        drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
